// File: rtl/fexp_share_arbiter.sv
// Round-robin arbiter that shares one fexp datapath among N_REQ requesters.
// Results return tagged with their requester id through an in-order, credit-limited FIFO.
module fexp_share_arbiter #(
    parameter int N_REQ     = 4,
    parameter int BIT_W     = 32,
    parameter int EXP_LAT   = 0,
    parameter int OUT_DEPTH = 4,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*BIT_W-1:0] req_data,
    output logic [BIT_W-1:0]       fexp_x,
    input  logic [BIT_W-1:0]       fexp_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [BIT_W-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [BIT_W-1:0]           fexp_x_q, fexp_x_d;
    logic [EXP_LAT:0]           tag_vld_q, tag_vld_d;
    logic [EXP_LAT:0][ID_W-1:0] tag_id_q, tag_id_d;
    logic [BIT_W-1:0]           mem_data_q [OUT_DEPTH];
    logic [BIT_W-1:0]           mem_data_d [OUT_DEPTH];
    logic [ID_W-1:0]            mem_id_q [OUT_DEPTH];
    logic [ID_W-1:0]            mem_id_d [OUT_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [BIT_W-1:0]           rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]            rsp_id_q, rsp_id_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic            can_issue, issue, push, pop;
    int              inflight;
    int              slot;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        slot        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            slot = (int'(rr_ptr_q) + k) % N_REQ;
            if (!grant_found && req_valid[slot]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(slot);
            end
        end
    end

    always_comb begin
        inflight = 0;
        for (int i = 0; i <= EXP_LAT; i++) begin
            inflight = inflight + int'(tag_vld_q[i]);
        end
    end

    // Credit counts every op already owning a future FIFO slot, so a push can never hit a full FIFO.
    assign can_issue = (inflight + int'(count_q)) < OUT_DEPTH;
    assign issue     = rst_n && grant_found && can_issue;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        fexp_x_d     = fexp_x_q;
        rr_ptr_d     = rr_ptr_q;
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = issue;
        tag_id_d[0]  = grant_idx;
        for (int i = 1; i <= EXP_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
        if (issue) begin
            fexp_x_d = req_data[int'(grant_idx)*BIT_W +: BIT_W];
            rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign push = tag_vld_q[EXP_LAT];
    assign pop  = (count_q != '0) && rsp_ready;

    always_comb begin
        mem_data_d = mem_data_q;
        mem_id_d   = mem_id_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = fexp_result;
            mem_id_d[wr_ptr_q]   = tag_id_q[EXP_LAT];
            wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        // Head is registered from the post-update storage; it holds its last value once empty.
        if (count_d != '0) begin
            rsp_data_d = mem_data_d[rd_ptr_d];
            rsp_id_d   = mem_id_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            fexp_x_q   <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_id_q[i]   <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            fexp_x_q   <= fexp_x_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            mem_data_q <= mem_data_d;
            mem_id_q   <= mem_id_d;
        end
    end

    assign fexp_x    = fexp_x_q;
    assign rsp_valid = (count_q != '0);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (tag_vld_q != '0) || rsp_valid;

endmodule

// File: tb/tb_fexp_share_arbiter.sv
// Bench for fexp_share_arbiter: directed scenarios then random traffic, all checked every
// cycle against a queue-based model of issue, in-flight ops and the output FIFO.
module tb_fexp_share_arbiter;
    localparam int N_REQ     = 4;
    localparam int BIT_W     = 32;
    localparam int EXP_LAT   = 0;
    localparam int OUT_DEPTH = 4;
    localparam int ID_W      = 2;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*BIT_W-1:0] req_data;
    logic [BIT_W-1:0]       fexp_x;
    logic [BIT_W-1:0]       fexp_result;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [BIT_W-1:0]       rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;

    fexp_share_arbiter #(
        .N_REQ(N_REQ), .BIT_W(BIT_W), .EXP_LAT(EXP_LAT), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .fexp_x(fexp_x), .fexp_result(fexp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    // Exact e^x for the directed operands, an arbitrary bijection elsewhere.
    function automatic logic [31:0] fexp_fn(input logic [31:0] x);
        case (x)
            32'h00000000: return 32'h3f800000;
            32'h3f800000: return 32'h402df854;
            32'hbf800000: return 32'h3ebc5ab2;
            32'h3f000000: return 32'h3fd3094c;
            default:      return {x[15:0], x[31:16]} ^ 32'h9e3779b9;
        endcase
    endfunction

    assign fexp_result = fexp_fn(fexp_x);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          id;
        int          rem;
    } op_t;

    op_t         m_infl[$];
    op_t         m_fifo[$];
    int          m_rr;
    logic [31:0] m_fx;
    logic [31:0] m_last_d;
    int          m_last_id;

    int          vectors;
    int          miscompares;
    logic [N_REQ-1:0] obs_ready;
    int          last_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_infl.delete();
        m_fifo.delete();
        m_rr      = 0;
        m_fx      = '0;
        m_last_d  = '0;
        m_last_id = 0;
    endtask

    function automatic int exp_grant();
        if (!rst_n) return -1;
        if (m_infl.size() + m_fifo.size() >= OUT_DEPTH) return -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (req_valid[(m_rr + k) % N_REQ]) return (m_rr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic check_outputs(input int g);
        logic [N_REQ-1:0] er;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        obs_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            chk("rsp_data", rsp_data, m_fifo[0].d);
            chk("rsp_id", 32'(rsp_id), 32'(m_fifo[0].id));
        end else begin
            chk("rsp_data_hold", rsp_data, m_last_d);
            chk("rsp_id_hold", 32'(rsp_id), 32'(m_last_id));
        end
        chk("busy", 32'(busy), 32'((m_infl.size() != 0) || (m_fifo.size() != 0)));
        chk("fexp_x", fexp_x, m_fx);
    endtask

    task automatic model_edge(input int g);
        op_t keep[$];
        op_t n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_fifo.size() != 0 && rsp_ready) void'(m_fifo.pop_front());
        foreach (m_infl[i]) begin
            n = m_infl[i];
            if (n.rem == 0) begin
                n.d = fexp_fn(n.d);
                m_fifo.push_back(n);
            end else begin
                n.rem--;
                keep.push_back(n);
            end
        end
        m_infl = keep;
        if (g >= 0) begin
            n.d   = req_data[g*BIT_W +: BIT_W];
            n.id  = g;
            n.rem = EXP_LAT;
            m_infl.push_back(n);
            m_fx = n.d;
            m_rr = (g + 1) % N_REQ;
        end
        if (m_fifo.size() != 0) begin
            m_last_d  = m_fifo[0].d;
            m_last_id = m_fifo[0].id;
        end
    endtask

    // Inputs are set at the falling edge; checks run 1 time unit later.
    task automatic tick();
        int g;
        #1;
        g = exp_grant();
        check_outputs(g);
        last_grant = g;
        @(posedge clk);
        model_edge(g);
        @(negedge clk);
    endtask

    task automatic set_data(input int ch, input logic [31:0] d);
        req_data[ch*BIT_W +: BIT_W] = d;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'h3f800000;
            2: return 32'hbf800000;
            3: return 32'h3f000000;
            default: return $urandom;
        endcase
    endfunction

    // Keeps operands stable while waiting; refreshes data after a handshake; rare voluntary drops.
    task automatic rand_requesters();
        for (int j = 0; j < N_REQ; j++) begin
            if (req_valid[j] && last_grant == j) begin
                req_valid[j] = ($urandom_range(0, 3) != 0);
                set_data(j, pick_operand());
            end else if (req_valid[j]) begin
                if ($urandom_range(0, 15) == 0) req_valid[j] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req_valid[j] = 1'b1;
                set_data(j, pick_operand());
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int accepts;
        int waited;
        int grants3;
        vectors     = 0;
        miscompares = 0;
        last_grant  = -1;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        rsp_ready   = 1'b0;
        model_reset();
        @(negedge clk);
        tick();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Single op on ch0, x=0.
        rsp_ready = 1'b1;
        set_data(0, 32'h00000000);
        req_valid = 4'b0001;
        tick();
        chk("t1_ready_same_cycle", 32'(obs_ready), 32'h1);
        req_valid = '0;
        tick();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_data", rsp_data, 32'h3f800000);
        chk("t1_rsp_id", 32'(rsp_id), 32'd0);
        tick();

        // All four requesters back-to-back from a fresh pointer.
        do_reset();
        set_data(0, 32'h00000000);
        set_data(1, 32'h3f800000);
        set_data(2, 32'hbf800000);
        set_data(3, 32'h3f000000);
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_grant_order", 32'(obs_ready), 32'(1 << (i % N_REQ)));
        end
        req_valid = '0;
        for (int i = 0; i < 3; i++) tick();

        // Credit exhaustion with the consumer stalled, then resume.
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        accepts   = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (obs_ready != '0) accepts++;
        end
        chk("t3_accepts", 32'(accepts), 32'd4);
        rsp_ready = 1'b1;
        tick();
        chk("t3_blocked_while_full", 32'(obs_ready), 32'd0);
        tick();
        chk("t3_resume_after_pop", 32'(obs_ready != '0), 32'd1);

        // Full FIFO draining while requests keep arriving.
        for (int i = 0; i < 12; i++) tick();
        req_valid = '0;
        for (int i = 0; i < 6; i++) tick();

        // Reset with three queued and one in flight.
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) tick();
        chk("t5_pre_busy", 32'(busy), 32'd1);
        req_valid = '0;
        do_reset();
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_fexp_x", fexp_x, 32'd0);
        rsp_ready = 1'b1;
        set_data(2, 32'h3f000000);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        chk("t5_rsp_id", 32'(rsp_id), 32'd2);
        chk("t5_rsp_data", rsp_data, 32'h3fd3094c);
        for (int i = 0; i < 3; i++) tick();

        // ch3 held, ch0 toggling: ch3 must never wait N_REQ cycles or more.
        set_data(3, 32'h3f800000);
        req_valid = 4'b1000;
        waited    = 0;
        grants3   = 0;
        for (int i = 0; i < 16; i++) begin
            req_valid[0] = i[0];
            set_data(0, $urandom);
            tick();
            if (obs_ready[3]) begin
                chk("t6_no_starvation", 32'(waited < N_REQ), 32'd1);
                grants3++;
                waited = 0;
            end else begin
                waited++;
            end
        end
        chk("t6_ch3_served", 32'(grants3 >= 3), 32'd1);
        req_valid = '0;
        for (int i = 0; i < 4; i++) tick();

        // Random traffic with random backpressure and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            rand_requesters();
            rsp_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 399) == 0) begin
                req_valid = '0;
                do_reset();
            end else begin
                tick();
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
